mult_div_unit: RTL and testbench

//  Iterative multiply/divide unit executing the R-type MULT/MULTU/DIV/DIVU operations

---
 rtl/mult_div_unit_pkg.sv | 38 +++
 rtl/mult_div_unit_step.sv | 43 ++++
 rtl/mult_div_unit.sv | 154 +++++++++++++++
 tb/tb_mult_div_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit and the decode path that
// feeds it: operation encodings, FSM states, R-type funct codes and small
// helpers for classifying an operation.
package mult_div_unit_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_FINISH = 2'b10
    } mdu_state_e;

    // R-type funct codes decoded by Control for the HI/LO group.
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    // Op[1] selects divide, Op[0] selects unsigned.
    function automatic logic op_is_div(input mdu_op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input mdu_op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mult_div_unit_step.sv
// mdu_step: one combinational iteration shared by multiply and divide.
//  acc       in   2*WIDTH  running accumulator {upper, lower}
//  operand   in   WIDTH    multiplicand (mult) or divisor (div)
//  div_mode  in   1        0 = shift-add multiply, 1 = restoring divide
//  acc_next  out  2*WIDTH  accumulator after this step (bit 0 is 0 in div mode)
//  q_bit     out  1        quotient bit produced by this divide step
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               div_mode,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        // Multiply: add the multiplicand into the upper half when the
        // current multiplier bit (acc[0]) is set, then shift right. The
        // carry lands in the top bit of the shifted accumulator.
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
            + ({1'b0, operand} & {(WIDTH+1){acc[0]}});

        // Divide: shift the next dividend bit into the partial remainder and
        // trial-subtract on WIDTH+1 bits. A set top bit of the difference
        // means the subtraction borrowed, so the remainder is restored.
        rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff   = rem_sh - {1'b0, operand};
        q_bit  = ~diff[WIDTH];

        if (div_mode) begin
            acc_next = {(q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                        acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU engine owning HI/LO.
//  Clock, ResetN          rising-edge clock, async active-low reset
//  Start, Op, A, B        operation request and operands
//  WriteHi/WriteLo/WriteData  MTHI/MTLO writes (honoured in IDLE only)
//  Busy                   operation in flight, pipeline must stall
//  Done, DivByZero        completion pulse and divide-by-zero status
//  Hi, Lo                 architectural HI/LO registers
//  DbgState               current FSM state for observation
//
// Handshake: Start is a single-cycle request honoured only while Busy is low
// (state IDLE); a Start while Busy is dropped, never queued. Busy stays high
// from the accepting edge until the edge that writes HI/LO, where Done pulses
// for one cycle with Busy already low, so a Start in the Done cycle is taken.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             WriteHi,
    input  logic             WriteLo,
    input  logic [WIDTH-1:0] WriteData,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic [1:0]       DbgState
);

    mdu_state_e         state, state_next;
    mdu_op_e            op_q;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               sign_a, sign_b, b_zero;
    logic [CNT_W-1:0]   cnt;
    logic               done_q, dz_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    // Operand conditioning at accept time: signed ops run on magnitudes.
    logic               in_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    assign in_signed = ~Op[0];
    assign a_neg     = in_signed & A[WIDTH-1];
    assign b_neg     = in_signed & B[WIDTH-1];
    assign a_mag     = a_neg ? -A : A;
    assign b_mag     = b_neg ? -B : B;

    logic [2*WIDTH-1:0] step_acc;
    logic               step_q;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .operand  (opnd),
        .div_mode (op_is_div(op_q)),
        .acc_next (step_acc),
        .q_bit    (step_q)
    );

    // Sign fixup: sign flags are only ever set for signed ops.
    logic               neg_res;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    assign neg_res = sign_a ^ sign_b;
    assign prod    = neg_res ? -acc : acc;
    assign quo     = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem     = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:   if (Start) state_next = S_RUN;
            S_RUN:    if (cnt == '0) state_next = S_FINISH;
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            op_q   <= MDU_MULT;
            acc    <= '0;
            opnd   <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            b_zero <= 1'b0;
            cnt    <= '0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (WriteHi) hi_q <= WriteData;
                    if (WriteLo) lo_q <= WriteData;
                    if (Start) begin
                        op_q   <= mdu_op_e'(Op);
                        // Multiplier / dividend sits in the low half for both.
                        acc    <= {{WIDTH{1'b0}}, a_mag};
                        opnd   <= b_mag;
                        sign_a <= a_neg;
                        sign_b <= b_neg;
                        b_zero <= (B == '0);
                        cnt    <= CNT_W'(WIDTH - 1);
                        dz_q   <= 1'b0;
                    end
                end
                S_RUN: begin
                    acc <= op_is_div(op_q) ? {step_acc[2*WIDTH-1:1], step_q}
                                           : step_acc;
                    cnt <= cnt - 1'b1;
                end
                S_FINISH: begin
                    done_q <= 1'b1;
                    if (op_is_div(op_q)) begin
                        // A zero divisor leaves HI/LO untouched.
                        if (b_zero) begin
                            dz_q <= 1'b1;
                        end else begin
                            hi_q <= rem;
                            lo_q <= quo;
                        end
                    end else begin
                        {hi_q, lo_q} <= prod;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy      = (state != S_IDLE);
    assign Done      = done_q;
    assign DivByZero = dz_q;
    assign Hi        = hi_q;
    assign Lo        = lo_q;
    assign DbgState  = state;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic         Clock = 1'b0;
  logic         ResetN = 1'b0;
  logic         Start = 1'b0;
  logic [1:0]   Op = 2'b00;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         WriteHi = 1'b0;
  logic         WriteLo = 1'b0;
  logic [W-1:0] WriteData = '0;
  logic         Busy, Done, DivByZero;
  logic [W-1:0] Hi, Lo;
  logic [1:0]   DbgState;

  always #5 Clock = ~Clock;

  mult_div_unit #(.WIDTH(W), .CNT_W(5)) dut (
    .Clock(Clock), .ResetN(ResetN), .Start(Start), .Op(Op), .A(A), .B(B),
    .WriteHi(WriteHi), .WriteLo(WriteLo), .WriteData(WriteData),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo),
    .DbgState(DbgState)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [64:0] exp_q[$];       // {div_by_zero, hi, lo}
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: architectural results from plain 64-bit arithmetic.
  function automatic logic [64:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic [W-1:0] cur_hi,
                                        input logic [W-1:0] cur_lo);
    longint sa, sb, sp, sq, sr;
    logic [63:0] ua, ub, up, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'b00: begin sp = sa * sb; return {1'b0, sp[63:0]}; end
      2'b01: begin up = ua * ub; return {1'b0, up}; end
      2'b10: begin
        if (b == '0) return {1'b1, cur_hi, cur_lo};
        sq = sa / sb;
        sr = sa % sb;
        return {1'b0, sr[31:0], sq[31:0]};
      end
      default: begin
        if (b == '0) return {1'b1, cur_hi, cur_lo};
        uq = ua / ub;
        ur = ua % ub;
        return {1'b0, ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Called away from the rising edge; returns 1 time unit after the accepting edge.
  task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic whi, input logic wlo, input logic [W-1:0] wdata);
    Start = 1'b1; Op = op; A = a; B = b;
    WriteHi = whi; WriteLo = wlo; WriteData = wdata;
    if (whi) model_hi = wdata;
    if (wlo) model_lo = wdata;
    exp_q.push_back(model(op, a, b, model_hi, model_lo));
    @(posedge Clock);
    #1;
    Start = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0;
  endtask

  task automatic do_write(input logic whi, input logic wlo, input logic [W-1:0] wdata);
    WriteHi = whi; WriteLo = wlo; WriteData = wdata;
    if (whi) model_hi = wdata;
    if (wlo) model_lo = wdata;
    @(posedge Clock);
    #1;
    WriteHi = 1'b0; WriteLo = 1'b0;
  endtask

  // Waits (bounded) for Done, counting Busy cycles; returns at the Done negedge.
  task automatic finish_op(input string tag, input int pre_busy);
    int n;
    bit seen;
    logic [64:0] e;
    n = pre_busy;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clock);
      if (Done) begin
        seen = 1'b1;
        break;
      end
      if (Busy) n++;
      check({tag, "_hold"}, {Hi, Lo}, {model_hi, model_lo});
    end
    check({tag, "_done"}, 64'(seen), 64'd1);
    check({tag, "_busy_cycles"}, 64'(n), 64'(W + 1));
    check({tag, "_busy_low"}, 64'(Busy), 64'd0);
    e = exp_q.pop_front();
    check({tag, "_hilo"}, {Hi, Lo}, e[63:0]);
    check({tag, "_dz"}, 64'(DivByZero), 64'(e[64]));
    model_hi = e[63:32];
    model_lo = e[31:0];
  endtask

  // ---------------- stimulus ----------------
  int pre;
  logic [1:0] r_op;
  logic [W-1:0] r_a, r_b;
  int sel;

  initial begin
    // reset state
    repeat (3) @(negedge Clock);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_dz", 64'(DivByZero), 64'd0);
    check("rst_hilo", {Hi, Lo}, 64'd0);
    ResetN = 1'b1;
    @(negedge Clock);
    check("post_rst_hilo", {Hi, Lo}, 64'd0);

    // T1 / T2 / T3
    launch(2'b01, 32'hFFFF_FFFF, 32'd2, 0, 0, '0);
    finish_op("t1_multu", 0);
    @(negedge Clock);
    check("t1_done_one_cycle", 64'(Done), 64'd0);
    check("t1_known", {Hi, Lo}, 64'h0000_0001_FFFF_FFFE);
    launch(2'b00, 32'hFFFF_FFFF, 32'd2, 0, 0, '0);
    finish_op("t2_mult", 0);
    check("t2_known", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    launch(2'b10, -32'sd7, 32'd2, 0, 0, '0);
    finish_op("t3_div", 0);
    check("t3_div_known", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    launch(2'b11, 32'd100, 32'd7, 0, 0, '0);
    finish_op("t3_divu", 0);
    check("t3_divu_known", {Hi, Lo}, {32'd2, 32'd14});

    // signed overflow wraps
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, '0);
    finish_op("ovf", 0);
    check("ovf_known", {Hi, Lo}, {32'h0, 32'h8000_0000});

    // T4 divide by zero keeps preset HI/LO, flag clears on next accepted Start
    do_write(1, 1, 32'hA5A5_A5A5);
    @(negedge Clock);
    check("t4_preset", {Hi, Lo}, {32'hA5A5_A5A5, 32'hA5A5_A5A5});
    launch(2'b11, 32'd1234, 32'd0, 0, 0, '0);
    finish_op("t4_divu0", 0);
    check("t4_known", {Hi, Lo, 63'(0), DivByZero} == {64'hA5A5_A5A5_A5A5_A5A5, 63'(0), 1'b1} ? 64'd1 : 64'd0, 64'd1);
    launch(2'b00, 32'd3, 32'd5, 0, 0, '0);
    @(negedge Clock);
    check("t4_dz_cleared", 64'(DivByZero), 64'd0);
    finish_op("t4_next", 1);

    // write in the Start cycle: result overwrites; zero divide keeps the write
    launch(2'b01, 32'd3, 32'd4, 1, 1, 32'h0000_1234);
    finish_op("wr_start_mul", 0);
    launch(2'b10, 32'd9, 32'd0, 0, 1, 32'h0BAD_F00D);
    finish_op("wr_start_div0", 0);

    // T5 Start and a write mid-RUN are ignored; Start in the Done cycle is taken
    launch(2'b00, 32'hFFFF_FFF9, 32'd6, 0, 0, '0);
    pre = 0;
    repeat (5) begin
      @(negedge Clock);
      if (Busy) pre++;
    end
    Start = 1'b1; Op = 2'b11; A = 32'd77; B = 32'd3;
    WriteHi = 1'b1; WriteData = 32'hDEAD_BEEF;
    @(posedge Clock);
    #1;
    Start = 1'b0; WriteHi = 1'b0;
    finish_op("t5_first", pre);
    launch(2'b11, 32'd1000, 32'd33, 0, 0, '0);
    finish_op("t5_second", 0);

    // T6 reset mid-divide
    launch(2'b10, 32'd100000, 32'd7, 0, 0, '0);
    repeat (10) @(negedge Clock);
    ResetN = 1'b0;
    #1;
    check("t6_busy", 64'(Busy), 64'd0);
    check("t6_hilo", {Hi, Lo}, 64'd0);
    check("t6_done", 64'(Done), 64'd0);
    void'(exp_q.pop_back());
    model_hi = '0;
    model_lo = '0;
    repeat (3) begin
      @(negedge Clock);
      check("t6_no_done", 64'(Done), 64'd0);
    end
    ResetN = 1'b1;
    @(negedge Clock);
    launch(2'b10, -32'sd100, 32'd7, 0, 0, '0);
    finish_op("t6_after", 0);

    // randomized operations with corner-biased operands
    for (int k = 0; k < 24; k++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a = $urandom;
      r_b = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: r_b = '0;
        1: r_b = '1;
        2: r_a = 32'h8000_0000;
        3: r_b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      launch(r_op, r_a, r_b, 0, 0, '0);
      finish_op("rnd", 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
